// File: rtl/dmr_fault_monitor_if.sv
// Signal bundle between the DMR fault monitor and its driver/consumer.
// Clock and reset stay as plain ports on the monitor itself.
interface dmr_fault_monitor_if #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
);
    logic                 enable;
    logic                 mismatch_in;
    logic [WIDTH-1:0]     value_a;
    logic [WIDTH-1:0]     value_b;
    logic                 ack;
    logic                 fault_flag;
    logic                 suspect;
    logic [WIDTH-1:0]     snap_a;
    logic [WIDTH-1:0]     snap_b;
    logic [CNT_WIDTH-1:0] fault_count;
    logic [CNT_WIDTH-1:0] glitch_count;

    modport master (
        output enable, mismatch_in, value_a, value_b, ack,
        input  fault_flag, suspect, snap_a, snap_b, fault_count, glitch_count
    );

    modport slave (
        input  enable, mismatch_in, value_a, value_b, ack,
        output fault_flag, suspect, snap_a, snap_b, fault_count, glitch_count
    );
endinterface

// File: rtl/dmr_fault_monitor.sv
// Glitch-filtering fault monitor behind the DMR mismatch tree: confirms persistent
// mismatches, snapshots the first diverging pair and keeps saturating statistics.
//
// state   | meaning
// IDLE    | monitoring disabled, mismatch ignored
// MONITOR | enabled, waiting for a mismatch sample
// SUSPECT | mismatch seen, counting consecutive samples
// FAULT   | fault confirmed, held until ack with mismatch clear
module dmr_fault_monitor #(
    parameter int WIDTH          = 4,
    parameter int CONFIRM_CYCLES = 3,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                clk,
    input  logic                reset,
    dmr_fault_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        SUSPECT = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [3:0] CONFIRM_W = 4'(CONFIRM_CYCLES);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_persist_cnt;
    logic [3:0]           w_persist_nxt;
    logic [3:0]           w_persist_inc;
    logic [WIDTH-1:0]     r_snap_a;
    logic [WIDTH-1:0]     r_snap_b;
    logic [WIDTH-1:0]     w_snap_a_nxt;
    logic [WIDTH-1:0]     w_snap_b_nxt;
    logic [CNT_WIDTH-1:0] r_fault_cnt;
    logic [CNT_WIDTH-1:0] r_glitch_cnt;
    logic [CNT_WIDTH-1:0] w_fault_cnt_nxt;
    logic [CNT_WIDTH-1:0] w_glitch_cnt_nxt;
    logic                 r_fault_flag;
    logic                 r_suspect;

    assign w_persist_inc = r_persist_cnt + 4'd1;

    always_comb begin
        w_state_nxt      = r_state;
        w_persist_nxt    = r_persist_cnt;
        w_snap_a_nxt     = r_snap_a;
        w_snap_b_nxt     = r_snap_b;
        w_fault_cnt_nxt  = r_fault_cnt;
        w_glitch_cnt_nxt = r_glitch_cnt;

        case (r_state)
            IDLE: begin
                w_persist_nxt = 4'd0;
                if (bus.enable) begin
                    w_state_nxt = MONITOR;
                end
            end

            MONITOR: begin
                if (!bus.enable) begin
                    w_state_nxt = IDLE;
                end else if (bus.mismatch_in) begin
                    w_snap_a_nxt  = bus.value_a;
                    w_snap_b_nxt  = bus.value_b;
                    w_persist_nxt = 4'd1;
                    // A single-sample confirm skips SUSPECT entirely
                    if (CONFIRM_W == 4'd1) begin
                        w_state_nxt = FAULT;
                        if (r_fault_cnt != '1) w_fault_cnt_nxt = r_fault_cnt + 1'b1;
                    end else begin
                        w_state_nxt = SUSPECT;
                    end
                end
            end

            SUSPECT: begin
                if (!bus.enable) begin
                    w_state_nxt   = IDLE;
                    w_persist_nxt = 4'd0;
                end else if (!bus.mismatch_in) begin
                    w_state_nxt   = MONITOR;
                    w_persist_nxt = 4'd0;
                    if (r_glitch_cnt != '1) w_glitch_cnt_nxt = r_glitch_cnt + 1'b1;
                end else begin
                    w_persist_nxt = w_persist_inc;
                    if (w_persist_inc == CONFIRM_W) begin
                        w_state_nxt = FAULT;
                        if (r_fault_cnt != '1) w_fault_cnt_nxt = r_fault_cnt + 1'b1;
                    end
                end
            end

            FAULT: begin
                // A still-active mismatch blocks the acknowledge
                if (bus.ack && !bus.mismatch_in) begin
                    w_state_nxt   = bus.enable ? MONITOR : IDLE;
                    w_persist_nxt = 4'd0;
                end
            end

            default: begin
                w_state_nxt   = IDLE;
                w_persist_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_persist_cnt <= 4'd0;
            r_snap_a      <= '0;
            r_snap_b      <= '0;
            r_fault_cnt   <= '0;
            r_glitch_cnt  <= '0;
            r_fault_flag  <= 1'b0;
            r_suspect     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_persist_cnt <= w_persist_nxt;
            r_snap_a      <= w_snap_a_nxt;
            r_snap_b      <= w_snap_b_nxt;
            r_fault_cnt   <= w_fault_cnt_nxt;
            r_glitch_cnt  <= w_glitch_cnt_nxt;
            r_fault_flag  <= (w_state_nxt == FAULT);
            r_suspect     <= (w_state_nxt == SUSPECT);
        end
    end

    assign bus.fault_flag   = r_fault_flag;
    assign bus.suspect      = r_suspect;
    assign bus.snap_a       = r_snap_a;
    assign bus.snap_b       = r_snap_b;
    assign bus.fault_count  = r_fault_cnt;
    assign bus.glitch_count = r_glitch_cnt;

endmodule

// File: tb/tb_dmr_fault_monitor.sv
// Directed bench for dmr_fault_monitor: main build (confirm 3), a 2-bit counter
// build for saturation and a confirm-1 build, all fed the same stimulus.
module tb_dmr_fault_monitor;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    typedef struct {
        string      tag;
        logic       f;
        logic       s;
        logic [3:0] sa;
        logic [3:0] sb;
        logic [7:0] fc;
        logic [7:0] gc;
    } exp_t;

    exp_t sb_q[$];

    dmr_fault_monitor_if #(.WIDTH(4), .CNT_WIDTH(8)) m_if ();
    dmr_fault_monitor_if #(.WIDTH(4), .CNT_WIDTH(2)) s_if ();
    dmr_fault_monitor_if #(.WIDTH(4), .CNT_WIDTH(8)) c_if ();

    assign s_if.enable      = m_if.enable;
    assign s_if.mismatch_in = m_if.mismatch_in;
    assign s_if.value_a     = m_if.value_a;
    assign s_if.value_b     = m_if.value_b;
    assign s_if.ack         = m_if.ack;
    assign c_if.enable      = m_if.enable;
    assign c_if.mismatch_in = m_if.mismatch_in;
    assign c_if.value_a     = m_if.value_a;
    assign c_if.value_b     = m_if.value_b;
    assign c_if.ack         = m_if.ack;

    dmr_fault_monitor #(.WIDTH(4), .CONFIRM_CYCLES(3), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .bus(m_if)
    );
    dmr_fault_monitor #(.WIDTH(4), .CONFIRM_CYCLES(3), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(s_if)
    );
    dmr_fault_monitor #(.WIDTH(4), .CONFIRM_CYCLES(1), .CNT_WIDTH(8)) dut_c1 (
        .clk(clk), .reset(reset), .bus(c_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input logic en, input logic mm, input logic [3:0] a,
                       input logic [3:0] b, input logic ak);
        m_if.enable      = en;
        m_if.mismatch_in = mm;
        m_if.value_a     = a;
        m_if.value_b     = b;
        m_if.ack         = ak;
        @(posedge clk);
        #1;
    endtask

    // Push the expected main-build outputs, clock the stimulus, pop and compare.
    task automatic step(input logic en, input logic mm, input logic [3:0] a,
                        input logic [3:0] b, input logic ak, input string tag,
                        input logic f, input logic s, input logic [3:0] sa,
                        input logic [3:0] sbv, input logic [7:0] fc, input logic [7:0] gc);
        exp_t e;
        exp_t got;
        e.tag = tag; e.f = f; e.s = s; e.sa = sa; e.sb = sbv; e.fc = fc; e.gc = gc;
        sb_q.push_back(e);
        cyc(en, mm, a, b, ak);
        got = sb_q.pop_front();
        chk({got.tag, ".fault"},   {7'd0, m_if.fault_flag}, {7'd0, got.f});
        chk({got.tag, ".suspect"}, {7'd0, m_if.suspect},    {7'd0, got.s});
        chk({got.tag, ".snap_a"},  {4'd0, m_if.snap_a},     {4'd0, got.sa});
        chk({got.tag, ".snap_b"},  {4'd0, m_if.snap_b},     {4'd0, got.sb});
        chk({got.tag, ".fcnt"},    m_if.fault_count,        got.fc);
        chk({got.tag, ".gcnt"},    m_if.glitch_count,       got.gc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".m_fault"}, {7'd0, m_if.fault_flag}, 8'd0);
        chk({tag, ".m_susp"},  {7'd0, m_if.suspect},    8'd0);
        chk({tag, ".m_snapa"}, {4'd0, m_if.snap_a},     8'd0);
        chk({tag, ".m_snapb"}, {4'd0, m_if.snap_b},     8'd0);
        chk({tag, ".m_fcnt"},  m_if.fault_count,        8'd0);
        chk({tag, ".m_gcnt"},  m_if.glitch_count,       8'd0);
        chk({tag, ".s_fcnt"},  {6'd0, s_if.fault_count},  8'd0);
        chk({tag, ".s_gcnt"},  {6'd0, s_if.glitch_count}, 8'd0);
        chk({tag, ".c_fault"}, {7'd0, c_if.fault_flag},   8'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;

        // Reset held for two edges
        cyc(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        chk_all_zero("reset");
        reset = 1'b1;

        // Enable and quiet run
        for (int i = 0; i < 21; i++)
            step(1, 0, 0, 0, 0, "quiet", 0, 0, 0, 0, 0, 0);

        // Two-cycle glitch
        step(1, 1, 5, 7, 0, "glitch_e0", 0, 1, 5, 7, 0, 0);
        step(1, 1, 5, 7, 0, "glitch_e1", 0, 1, 5, 7, 0, 0);
        step(1, 0, 0, 0, 0, "glitch_end", 0, 0, 5, 7, 0, 1);

        // Confirmed fault, snapshot from first sample only
        step(1, 1,  9, 8, 0, "conf_e0", 0, 1, 9, 8, 0, 1);
        step(1, 1, 10, 8, 0, "conf_e1", 0, 1, 9, 8, 0, 1);
        step(1, 1, 10, 8, 0, "conf_e2", 1, 0, 9, 8, 1, 1);
        step(1, 1, 10, 8, 0, "conf_e3", 1, 0, 9, 8, 1, 1);

        // Ack blocked by mismatch, then accepted -> MONITOR
        step(1, 1, 10, 8, 1, "ack_blocked", 1, 0, 9, 8, 1, 1);
        step(1, 0,  0, 0, 1, "ack_ok",      0, 0, 9, 8, 1, 1);
        step(1, 1,  3, 4, 0, "mon_direct",  0, 1, 3, 4, 1, 1);
        step(1, 1,  3, 4, 0, "f2_e1",       0, 1, 3, 4, 1, 1);
        step(1, 1,  3, 4, 0, "f2_e2",       1, 0, 3, 4, 2, 1);
        step(0, 1,  3, 4, 0, "fault_en0",   1, 0, 3, 4, 2, 1);
        step(0, 0,  0, 0, 1, "ack_to_idle", 0, 0, 3, 4, 2, 1);
        step(0, 1,  6, 6, 0, "idle_ignore", 0, 0, 3, 4, 2, 1);
        step(1, 1,  6, 6, 0, "idle_to_mon", 0, 0, 3, 4, 2, 1);
        step(1, 1,  6, 6, 0, "mon_susp",    0, 1, 6, 6, 2, 1);
        step(1, 0,  0, 0, 0, "glitch2",     0, 0, 6, 6, 2, 2);
        step(1, 1,  2, 1, 0, "susp_again",  0, 1, 2, 1, 2, 2);
        step(0, 1,  2, 1, 0, "susp_dis",    0, 0, 2, 1, 2, 2);

        // Reset during FAULT
        step(1, 0,  0, 0, 0, "re_en",  0, 0, 2, 1, 2, 2);
        step(1, 1,  1, 2, 0, "f3_e0",  0, 1, 1, 2, 2, 2);
        step(1, 1,  1, 2, 0, "f3_e1",  0, 1, 1, 2, 2, 2);
        step(1, 1,  1, 2, 0, "f3_e2",  1, 0, 1, 2, 3, 2);
        reset = 1'b0;
        cyc(1, 1, 1, 2, 0);
        chk_all_zero("reset_mid_fault");
        reset = 1'b1;

        // Saturation on the 2-bit counter build
        cyc(1, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 1, 4'(k), 0, 0);
            cyc(1, 0, 0, 0, 0);
            chk($sformatf("sat_glitch%0d", k), {6'd0, s_if.glitch_count}, (k > 3) ? 8'd3 : 8'(k));
            chk($sformatf("main_glitch%0d", k), m_if.glitch_count, 8'(k));
        end
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 1, 1, 0, 0);
            cyc(1, 1, 1, 0, 0);
            cyc(1, 1, 1, 0, 0);
            chk($sformatf("sat_flag%0d", k), {7'd0, s_if.fault_flag}, 8'd1);
            cyc(1, 0, 0, 0, 1);
            chk($sformatf("sat_fault%0d", k), {6'd0, s_if.fault_count}, (k > 3) ? 8'd3 : 8'(k));
            chk($sformatf("sat_gl_hold%0d", k), {6'd0, s_if.glitch_count}, 8'd3);
        end

        // Confirm-1 build: one sample confirms, suspect never raised
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk_all_zero("reset2");
        reset = 1'b1;
        cyc(1, 0, 0, 0, 0);
        chk("c1_mon_flag", {7'd0, c_if.fault_flag}, 8'd0);
        cyc(1, 1, 11, 4, 0);
        chk("c1_flag",   {7'd0, c_if.fault_flag}, 8'd1);
        chk("c1_susp",   {7'd0, c_if.suspect},    8'd0);
        chk("c1_snap_a", {4'd0, c_if.snap_a},     8'd11);
        chk("c1_snap_b", {4'd0, c_if.snap_b},     8'd4);
        chk("c1_fcnt",   c_if.fault_count,        8'd1);
        chk("c1_main_s", {7'd0, m_if.suspect},    8'd1);
        cyc(1, 1, 12, 5, 1);
        chk("c1_blk_flag", {7'd0, c_if.fault_flag}, 8'd1);
        chk("c1_blk_susp", {7'd0, c_if.suspect},    8'd0);
        chk("c1_blk_snap", {4'd0, c_if.snap_a},     8'd11);
        cyc(1, 0, 0, 0, 1);
        chk("c1_ack_flag", {7'd0, c_if.fault_flag}, 8'd0);
        chk("c1_ack_susp", {7'd0, c_if.suspect},    8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmr_fault_monitor.md
Name: dmr_fault_monitor

Overview:
- Downstream consumer of the dual-modular-redundancy comparator/XOR/OR tree: watches the combined mismatch line `result` and the two redundant counter values.
- Filters single-cycle glitches; declares a confirmed fault when a mismatch persists for CONFIRM_CYCLES consecutive clocks.
- Snapshots the first diverging value pair and keeps saturating fault and glitch statistics.
- Holds the fault until software acknowledges it.

Parameters:
- WIDTH, 4: width of each redundant value (matches the 4-bit counters).
- CONFIRM_CYCLES, 3: consecutive mismatch samples needed to confirm a fault; legal range 1..15.
- CNT_WIDTH, 8: width of the event and glitch statistics counters.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- enable  input  1  monitoring enable
- mismatch_in  input  1  combined mismatch flag from the XOR/OR tree
- value_a  input  WIDTH  redundant channel A value
- value_b  input  WIDTH  redundant channel B value
- ack  input  1  fault acknowledge, level-sampled
- fault_flag  output  1  confirmed fault, registered
- suspect  output  1  high while in SUSPECT, registered
- snap_a  output  WIDTH  channel A value at first mismatch sample of the current episode
- snap_b  output  WIDTH  channel B value at first mismatch sample of the current episode
- fault_count  output  CNT_WIDTH  confirmed faults, saturating
- glitch_count  output  CNT_WIDTH  rejected mismatch episodes, saturating

Behaviour:
- All inputs are sampled on the rising clk edge.
- All outputs are registered; there is no combinational input-to-output path.

Reset:
- Applies when reset==0 at an edge and overrides everything else.
- State=IDLE; all outputs 0; internal persist_cnt=0.

FSM states: IDLE, MONITOR, SUSPECT, FAULT.

IDLE:
- enable=1 -> MONITOR.
- mismatch_in is ignored.

MONITOR, checked in this order:
- enable=0 -> IDLE.
- Otherwise, mismatch_in=1:
  - Load snap_a/snap_b from value_a/value_b of this edge.
  - Set persist_cnt=1.
  - If CONFIRM_CYCLES==1, go directly to FAULT (same actions as the confirm entry below).
  - Otherwise go to SUSPECT.

SUSPECT, checked in this order:
- enable=0 -> IDLE. Clear persist_cnt; no counters change.
- mismatch_in=0 -> MONITOR. Increment glitch_count, saturating at all-ones. Snapshots retain their values.
- mismatch_in=1:
  - Increment persist_cnt.
  - When the incremented value equals CONFIRM_CYCLES -> FAULT.
  - On FAULT entry: fault_flag=1, suspect=0, fault_count incremented (saturating).
  - Snapshots are not reloaded during the episode.

FAULT:
- fault_flag stays 1; enable and mismatch_in are ignored, except that mismatch_in blocks ack as below.
- ack=1 and mismatch_in=0 at the same edge:
  - Go to MONITOR if enable=1, else IDLE.
  - fault_flag clears at that edge.
  - persist_cnt is cleared.
- ack=1 while mismatch_in=1: ignored; stays in FAULT.

Latency:
- Mismatch first sampled at edge e0 -> suspect=1 after e0.
- With CONFIRM_CYCLES=3 and mismatch held through e1 and e2 -> fault_flag=1 after e2, i.e. exactly CONFIRM_CYCLES edges after the first sample.

Saturation:
- At all-ones, fault_count and glitch_count hold.
- Counters clear only on reset.

Snapshots:
- Overwritten only on MONITOR->SUSPECT or MONITOR->FAULT transitions.
- Stable while in SUSPECT or FAULT.

Output relations:
- suspect==1 exactly when state==SUSPECT.
- fault_flag==1 exactly when state==FAULT.
- fault_flag and suspect are never both 1.

Reset mid-operation:
- Reset while in SUSPECT or FAULT returns to IDLE.
- Snapshots and counters clear at that edge.

Test Plan:
- Reset/enable: hold reset=0 for 2 edges, then reset=1, enable=1 -> all outputs 0; state MONITOR after 1 edge; mismatch-free run of 20 cycles leaves all counters 0.
- Glitch rejection (CONFIRM_CYCLES=3): pulse mismatch_in for 2 cycles with value_a=5, value_b=7 -> suspect=1 for 2 cycles, fault_flag stays 0, glitch_count=1, snap_a=5, snap_b=7.
- Confirmed fault: hold mismatch_in=1 for 4 cycles with first values a=9, b=8 and later values a=10, b=8 -> fault_flag=1 exactly 3 edges after the first sample, fault_count=1, snap_a=9 (not 10).
- Ack handshake: in FAULT, assert ack with mismatch_in=1 -> fault_flag stays 1; drop mismatch_in with ack=1 -> fault_flag=0 next edge, state MONITOR; then with enable=0, a fresh fault plus ack -> IDLE.
- Saturation (CNT_WIDTH=2): generate 5 single-cycle glitches -> glitch_count sticks at 3; generate 5 acked faults -> fault_count sticks at 3.
- Reset mid-fault and CONFIRM_CYCLES=1: reset=0 during FAULT -> all outputs 0 next edge. In a separate CONFIRM_CYCLES=1 build, a single mismatch sample -> fault_flag=1 after that edge with suspect never asserted.
